// File: rtl/uio_arb_pkg.sv
// -----------------------------------------------------------------------------
// uio_arb_pkg
//   Shared types and constants for the uio pad-group arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, TURN, OWN)
//   - PAD_W       : width of the uio pad group
//   - OE_DRIVE    : output-enable pattern while a requester drives the pads
//   - OE_SAMPLE   : output-enable pattern while the pads are released
//   - clog2()     : index/counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package uio_arb_pkg;

  localparam int PAD_W = 8;

  localparam logic [PAD_W-1:0] OE_DRIVE  = 8'hFF;
  localparam logic [PAD_W-1:0] OE_SAMPLE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  // A width of at least one bit keeps single-entry counters and indices legal.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Starting one position after i_ptr and
//   wrapping around, the first set request bit wins. The pointer position
//   itself is examined last, so the previous owner has lowest priority.
//
//   Ports:
//     i_req    [NREQ]  request vector
//     i_ptr    [IDX_W] index of the most recent winner
//     o_onehot [NREQ]  one-hot winner (all zero when no request)
//     o_idx    [IDX_W] winner index (zero when no request)
//     o_any            at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    // NOTE: every output gets a default before the search loop; a path that
    // leaves an output unassigned would infer a latch.
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_any && i_req[IDX_W'((int'(i_ptr) + k) % NREQ)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
      end
    end
    o_onehot[o_idx] = o_any;
  end

endmodule

// File: rtl/uio_port_arbiter.sv
// -----------------------------------------------------------------------------
// uio_port_arbiter
//   Shares the 8-bit bidirectional uio pad group between NREQ requesters.
//   A requester either drives the pads (dir=1) or samples them (dir=0).
//   Round-robin selection, a turnaround gap with the pads released on every
//   direction change, and a hold-time limit keep one requester from starving
//   the others.
//
//   Parameters:
//     NREQ      number of requesters (2..8)
//     HOLD_MAX  max OWN cycles while another request is pending (>=2)
//     TURN_CYC  released-pad cycles inserted on a direction change (>=1)
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     ena          design enable; low returns to IDLE and releases the pads
//     req  [NREQ]  level request per requester
//     dir  [NREQ]  1 = drive pads, 0 = sample pads (valid with req)
//     wdata[8*NREQ] drive data, requester i at [8i+7:8i]
//     gnt  [NREQ]  one-hot grant, high only while owning
//     rdata[8]     registered uio_in, updated while a sampling owner holds
//     uio_in[8]    pad input
//     uio_out[8]   pad output data (registered)
//     uio_oe[8]    pad output enable, all ones or all zeros (registered)
//     busy         arbiter not idle
//     timeout      one-cycle pulse after a hold-limit forced release
//
//   Build option:
//     UIO_ARB_LOCK_EN  adds input lock[NREQ]; while lock[owner] is set the
//                      hold limit is suspended and the owner keeps the pads
//                      until it drops its request.
// -----------------------------------------------------------------------------
module uio_port_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 16,
  parameter int TURN_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [NREQ*PAD_W-1:0] wdata,
`ifdef UIO_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  input  logic [PAD_W-1:0]      uio_in,
  output logic [NREQ-1:0]       gnt,
  output logic [PAD_W-1:0]      rdata,
  output logic [PAD_W-1:0]      uio_out,
  output logic [PAD_W-1:0]      uio_oe,
  output logic                  busy,
  output logic                  timeout
);

  localparam int IDX_W  = clog2(NREQ);
  localparam int HOLD_W = clog2(HOLD_MAX);
  localparam int TURN_W = clog2(TURN_CYC + 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  arb_state_e        r_state;
  arb_state_e        w_next_state;

  logic [IDX_W-1:0]  r_owner;     // index of the current/pending owner
  logic [NREQ-1:0]   r_owner_oh;  // same owner, one-hot, drives gnt
  logic [IDX_W-1:0]  r_rr_ptr;    // most recent winner
  logic              r_own_dir;   // direction latched at grant
  logic              r_last_dir;  // direction the pads were last set up for
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [TURN_W-1:0] r_turn_cnt;
  logic [PAD_W-1:0]  r_uio_oe;
  logic [PAD_W-1:0]  r_uio_out;
  logic [PAD_W-1:0]  r_rdata;
  logic              r_timeout;

  // ---------------------------------------------------------------------------
  // Picker and owner-side views of the inputs
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [PAD_W-1:0]  w_wdata_arr [NREQ];
  logic              w_req_own;
  logic              w_others;
  logic              w_lock_own;
  logic              w_hold_full;
  logic              w_turn_done;
  logic              w_forced;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_wdata
    assign w_wdata_arr[g] = wdata[g*PAD_W +: PAD_W];
  end

  assign w_req_own   = req[r_owner];
  assign w_others    = |(req & ~r_owner_oh);
  assign w_hold_full = (r_hold_cnt == HOLD_W'(HOLD_MAX - 1));
  assign w_turn_done = (r_turn_cnt == TURN_W'(TURN_CYC - 1));

`ifdef UIO_ARB_LOCK_EN
  assign w_lock_own = lock[r_owner];
`else
  assign w_lock_own = 1'b0;
`endif

  // A voluntary release (req dropped) always wins over a forced one, so the
  // timeout pulse only marks releases the owner did not ask for.
  assign w_forced = ena && (r_state == OWN) && w_req_own && w_others &&
                    w_hold_full && !w_lock_own;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (!ena) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any)
            w_next_state = (dir[w_pick_idx] != r_last_dir) ? TURN : OWN;
        end
        TURN: begin
          if (!w_req_own)       w_next_state = IDLE;
          else if (w_turn_done) w_next_state = OWN;
        end
        OWN: begin
          if (!w_req_own || w_forced) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt  = (r_state == OWN) ? r_owner_oh : '0;
    busy = (r_state != IDLE);
  end

  assign uio_oe  = r_uio_oe;
  assign uio_out = r_uio_out;
  assign rdata   = r_rdata;
  assign timeout = r_timeout;

  // ---------------------------------------------------------------------------
  // Datapath: owner bookkeeping, counters and pad registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the pad registers are reset along with the control state so an
    // asynchronous reset releases the pads immediately, without a clock.
    if (!rst_n) begin
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_rr_ptr   <= IDX_W'(NREQ - 1);
      r_own_dir  <= 1'b0;
      r_last_dir <= 1'b0;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_uio_oe   <= OE_SAMPLE;
      r_uio_out  <= '0;
      r_rdata    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_forced;
      if (!ena) begin
        // The rr pointer survives a disable so fairness resumes where it left.
        r_uio_oe   <= OE_SAMPLE;
        r_last_dir <= 1'b0;
        r_hold_cnt <= '0;
        r_turn_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_any) begin
              r_owner    <= w_pick_idx;
              r_owner_oh <= w_pick_onehot;
              r_rr_ptr   <= w_pick_idx;
              r_own_dir  <= dir[w_pick_idx];
              r_hold_cnt <= '0;
              r_turn_cnt <= '0;
              // Release the pads for the whole turnaround gap; on a
              // same-direction handover uio_oe is left untouched.
              if (dir[w_pick_idx] != r_last_dir) r_uio_oe <= OE_SAMPLE;
            end
          end
          TURN: begin
            if (w_req_own) begin
              if (w_turn_done) r_last_dir <= r_own_dir;
              else             r_turn_cnt <= r_turn_cnt + 1'b1;
            end
          end
          OWN: begin
            r_uio_oe  <= r_last_dir ? OE_DRIVE : OE_SAMPLE;
            r_uio_out <= w_wdata_arr[r_owner];
            if (!r_last_dir) r_rdata <= uio_in;
            // Saturates at HOLD_MAX-1; a lock freezes it in place.
            if (!w_hold_full && !w_lock_own) r_hold_cnt <= r_hold_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uio_port_arbiter
//   Self-checking bench for uio_port_arbiter: directed scenarios followed by a
//   long randomized run, every cycle compared against a behavioural model.
//   Build with UIO_ARB_LOCK_EN defined to exercise the lock input.
// -----------------------------------------------------------------------------
module tb_uio_port_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 16;
  localparam int TURN_CYC = 1;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              ena    = 1'b0;
  logic [NREQ-1:0]   req    = '0;
  logic [NREQ-1:0]   dir    = '0;
  logic [NREQ*8-1:0] wdata  = '0;
  logic [7:0]        uio_in = '0;
`ifdef UIO_ARB_LOCK_EN
  logic [NREQ-1:0]   lock   = '0;
`endif

  logic [NREQ-1:0]   gnt;
  logic [7:0]        rdata;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic              busy;
  logic              timeout;

  uio_port_arbiter #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
`ifdef UIO_ARB_LOCK_EN
    .lock    (lock),
`endif
    .uio_in  (uio_in),
    .gnt     (gnt),
    .rdata   (rdata),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_owner < 0      : nobody holds or waits for the pads
  //   m_gap > 0        : owner chosen, pads released for m_gap more cycles
  //   m_owner >= 0, m_gap == 0 : owner holds the pads (m_held cycles so far)
  // ---------------------------------------------------------------------------
  int         m_owner;
  int         m_gap;
  int         m_ptr;
  int         m_held;
  logic       m_own_dir;
  logic       m_last_dir;
  logic       m_timeout;
  logic [7:0] m_oe;
  logic [7:0] m_out;
  logic [7:0] m_rdata;

  task automatic model_reset();
    m_owner    = -1;
    m_gap      = 0;
    m_ptr      = NREQ - 1;
    m_held     = 0;
    m_own_dir  = 1'b0;
    m_last_dir = 1'b0;
    m_timeout  = 1'b0;
    m_oe       = 8'h00;
    m_out      = 8'h00;
    m_rdata    = 8'h00;
  endtask

  task automatic model_step();
    int   pick;
    logic lk;
    logic others;
    m_timeout = 1'b0;
    if (!ena) begin
      m_owner    = -1;
      m_gap      = 0;
      m_oe       = 8'h00;
      m_last_dir = 1'b0;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (pick < 0 && req[c]) pick = c;
      end
      if (pick >= 0) begin
        m_owner   = pick;
        m_ptr     = pick;
        m_held    = 0;
        m_own_dir = dir[pick];
        if (dir[pick] != m_last_dir) begin
          m_gap = TURN_CYC;
          m_oe  = 8'h00;
        end
      end
    end else if (m_gap > 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = 0;
      end else begin
        m_gap--;
        if (m_gap == 0) m_last_dir = m_own_dir;
      end
    end else begin
      m_oe  = m_last_dir ? 8'hFF : 8'h00;
      m_out = wdata[m_owner*8 +: 8];
      if (!m_last_dir) m_rdata = uio_in;
      lk = 1'b0;
`ifdef UIO_ARB_LOCK_EN
      lk = lock[m_owner];
`endif
      others = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (i != m_owner && req[i]) others = 1'b1;
      if (!req[m_owner]) begin
        m_owner = -1;
      end else if (others && !lk && m_held >= HOLD_MAX - 1) begin
        m_owner   = -1;
        m_timeout = 1'b1;
      end else if (!lk) begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] e_gnt;
    e_gnt = '0;
    if (m_owner >= 0 && m_gap == 0) e_gnt[m_owner] = 1'b1;
    check("gnt",     32'(gnt),     32'(e_gnt));
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("uio_oe",  32'(uio_oe),  32'(m_oe));
    check("uio_out", 32'(uio_out), 32'(m_out));
    check("rdata",   32'(rdata),   32'(m_rdata));
    check("timeout", 32'(timeout), 32'(m_timeout));
  endtask

  // One clock: the model advances on the edge with the same inputs the DUT
  // saw, outputs are compared on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    ena    = 1'b1;
    req    = '0;
    dir    = '0;
    wdata  = '0;
    uio_in = '0;
`ifdef UIO_ARB_LOCK_EN
    lock   = '0;
`endif
    #1;
    check("rst_gnt",     32'(gnt),     32'h0);
    check("rst_uio_oe",  32'(uio_oe),  32'h0);
    check("rst_uio_out", 32'(uio_out), 32'h0);
    check("rst_rdata",   32'(rdata),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(19) == 0) req[i] = ~req[i];
      if ($urandom_range(15) == 0) dir[i] = ~dir[i];
      wdata[i*8 +: 8] = 8'($urandom);
`ifdef UIO_ARB_LOCK_EN
      if ($urandom_range(7) == 0) lock[i] = ~lock[i];
`endif
    end
    uio_in = 8'($urandom);
    ena    = ($urandom_range(63) != 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hold_len;
    int to_cnt;

    // Drive requester 0 after reset: one turnaround cycle, then ownership.
    do_reset();
    req = 4'b0001;
    dir = 4'b0001;
    wdata[7:0] = 8'hA5;
    cycle(); check("s1_gap_gnt", 32'(gnt), 32'h0);
    cycle(); check("s1_gnt",     32'(gnt), 32'h1);
    cycle(); check("s1_oe",      32'(uio_oe),  32'hFF);
             check("s1_out",     32'(uio_out), 32'hA5);

    // Asynchronous reset while driving: pads released with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),    32'h0);
    check("arst_oe",   32'(uio_oe), 32'h0);
    check("arst_busy", 32'(busy),   32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    dir   = 4'b0000;
    cycle(); check("arst_prio", 32'(gnt), 32'h1);

    // Sampling owners, same-direction handover without a gap.
    req = 4'b0000;
    cycle();
    req    = 4'b1010;
    uio_in = 8'h3C;
    cycle(); check("s2_first", 32'(gnt), 32'b0010);
    cycle(); check("s2_rdata", 32'(rdata),  32'h3C);
             check("s2_oe",    32'(uio_oe), 32'h00);
    req = 4'b1000;
    cycle();
    cycle(); check("s2_next",    32'(gnt),    32'b1000);
             check("s2_oe_hold", 32'(uio_oe), 32'h00);

    // Hold limit: requester 0 keeps asking while requester 2 waits.
    do_reset();
    req = 4'b0101;
    hold_len = 0;
    to_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (gnt[0]) hold_len++;
      if (timeout) to_cnt++;
    end
    check("hold_len",  32'(hold_len), 32'(HOLD_MAX));
    check("hold_to",   32'(to_cnt),   32'h1);
    check("hold_next", 32'(gnt),      32'b0100);

    // Disable during ownership; the rr pointer survives.
    do_reset();
    req = 4'b0001;
    cycle();
    ena = 1'b0;
    cycle(); check("ena_gnt",  32'(gnt),  32'h0);
             check("ena_busy", 32'(busy), 32'h0);
    ena = 1'b1;
    req = 4'b0011;
    cycle(); check("ena_ptr", 32'(gnt), 32'b0010);

`ifdef UIO_ARB_LOCK_EN
    // A locked owner is never forced off.
    do_reset();
    req  = 4'b0101;
    lock = 4'b0001;
    hold_len = 0;
    to_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (gnt[0]) hold_len++;
      if (timeout) to_cnt++;
    end
    check("lock_to",  32'(to_cnt),   32'h0);
    check("lock_len", 32'(hold_len), 32'd40);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
